// File: rtl/mig_u_fetch.sv
// Mig-U instruction fetch front end: fetch PC, in-order word requests with a bounded
// outstanding count, a registered instruction queue, redirect flush and fault halt.
module mig_u_fetch #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned BUF_DEPTH       = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-3:0] rst_addr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-3:0] redirect_addr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-3:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_data,
  input  logic                  mem_rsp_err,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [31:0]           insn_data,
  output logic [ADDR_WIDTH-3:0] insn_addr,
  output logic                  insn_err
);

  localparam int unsigned AW = ADDR_WIDTH - 2;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned OW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PW = $clog2(BUF_DEPTH);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   rsp_addr_q, rsp_addr_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [OW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     data_q [BUF_DEPTH];
  logic [AW-1:0]   addr_q [BUF_DEPTH];
  logic            err_q  [BUF_DEPTH];

  logic req_hs, push, pop, discard;

  // Slots are reserved for every outstanding request so the queue cannot overflow.
  assign mem_req_valid = !rst && (state_q == StRun) && !redirect_valid
                         && (32'(out_q) < MAX_OUTSTANDING)
                         && (32'(count_q) + 32'(out_q) < BUF_DEPTH);
  assign mem_req_addr  = pc_q;
  assign req_hs        = mem_req_valid && mem_req_ready;

  assign insn_valid = (count_q != '0);
  assign insn_data  = data_q[rd_ptr_q];
  assign insn_addr  = addr_q[rd_ptr_q];
  assign insn_err   = err_q[rd_ptr_q];
  assign pop        = insn_valid && insn_ready;

  assign discard = (drop_q != '0);
  assign push    = mem_rsp_valid && !discard && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_addr_d = rsp_addr_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    out_d      = out_q + CW'(req_hs) - CW'(mem_rsp_valid);
    count_d    = count_q + OW'(push) - OW'(pop);

    if (req_hs) pc_d = pc_q + AW'(1);
    if (mem_rsp_valid && discard) drop_d = drop_q - CW'(1);
    if (push) begin
      rsp_addr_d = rsp_addr_q + AW'(1);
      wr_ptr_d   = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    // A fault stops fetching; everything still in flight behind it is thrown away.
    if (push && mem_rsp_err) begin
      state_d = StHalt;
      drop_d  = out_d;
    end

    if (redirect_valid) begin
      state_d    = StRun;
      pc_d       = redirect_addr;
      rsp_addr_d = redirect_addr;
      drop_d     = out_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      pc_q       <= rst_addr;
      rsp_addr_q <= rst_addr;
      out_q      <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_addr_q <= rsp_addr_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
        err_q[i]  <= 1'b0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= mem_rsp_data;
      addr_q[wr_ptr_q] <= rsp_addr_q;
      err_q[wr_ptr_q]  <= mem_rsp_err;
    end
  end

  // A response with nothing outstanding means the memory side broke protocol.
  assert property (@(posedge clk) disable iff (rst) mem_rsp_valid |-> (out_q != '0));

endmodule

// File: tb/tb_mig_u_fetch.sv
// Bench for mig_u_fetch: 1-cycle-latency memory model, request/insn scoreboard monitor
// and directed phases for throughput, backpressure, redirect, fault, wrap, stall and reset.
module tb_mig_u_fetch;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rst_addr;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  logic          mem_rsp_err;
  logic          insn_valid;
  logic          insn_ready;
  logic [31:0]   insn_data;
  logic [AW-1:0] insn_addr;
  logic          insn_err;

  mig_u_fetch #(
    .ADDR_WIDTH(32),
    .BUF_DEPTH(4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rst_addr(rst_addr),
    .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err),
    .insn_valid(insn_valid),
    .insn_ready(insn_ready),
    .insn_data(insn_data),
    .insn_addr(insn_addr),
    .insn_err(insn_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] pend[$];
  logic [AW-1:0] exp_pc;
  logic [AW-1:0] err_addr;
  logic [AW-1:0] fault_addr;
  logic          err_en, rsp_hold, err_seen;
  int            n_checks = 0, n_fail = 0, n_pops = 0, req_count = 0;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [AW-1:0] a);
    tick();
    redirect_addr  = a;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 64'(mem_req_valid), 64'(0));
    check({tag, "_req_addr"}, 64'(mem_req_addr), 64'(30'h100));
    check({tag, "_insn_valid"}, 64'(insn_valid), 64'(0));
    check({tag, "_insn_data"}, 64'(insn_data), 64'(0));
    check({tag, "_insn_addr"}, 64'(insn_addr), 64'(0));
    check({tag, "_insn_err"}, 64'(insn_err), 64'(0));
  endtask

  task automatic wait_insn_addr(input string name, input logic [AW-1:0] a);
    bit found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (insn_valid) found = 1;
    end
    check(name, found ? 64'(insn_addr) : 64'hdead, 64'(a));
  endtask

  // Memory model: accepted addresses answer one per cycle, one cycle after acceptance.
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) pend.delete();
      else if (mem_req_valid && mem_req_ready) pend.push_back(mem_req_addr);
      @(posedge clk);
      #2;
      if (rst) pend.delete();
      if (!rst && !rsp_hold && pend.size() > 0) begin
        logic [AW-1:0] a;
        a = pend.pop_front();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(a);
        mem_rsp_err   = err_en && (a == err_addr);
      end else begin
        mem_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: checks request addresses in order and each delivered insn against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_pc = rst_addr;
        continue;
      end
      if (insn_valid && insn_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL insn_unexpected: got addr 0x%0h, expected no insn", insn_addr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("insn", {insn_err, insn_addr, insn_data}, {e.err, e.addr, e.data});
          if (e.err) begin
            exp_q.delete();
            err_seen   = 1'b1;
            fault_addr = insn_addr;
          end
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        exp_t e;
        req_count++;
        check("req_addr", 64'(mem_req_addr), 64'(exp_pc));
        e.addr = exp_pc;
        e.data = mem_word(exp_pc);
        e.err  = err_en && (exp_pc == err_addr);
        exp_q.push_back(e);
        exp_pc = exp_pc + 1'b1;
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_pc = redirect_addr;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start;
    logic [AW-1:0] a0;
    rst            = 1'b1;
    rst_addr       = 30'h100;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    mem_req_ready  = 1'b1;
    insn_ready     = 1'b1;
    rsp_hold       = 1'b0;
    err_en         = 1'b0;
    err_addr       = 30'h102;
    err_seen       = 1'b0;
    fault_addr     = '0;
    exp_pc         = 30'h100;

    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", 64'(mem_req_valid), 64'(1));
    check("first_req_addr", 64'(mem_req_addr), 64'(30'h100));

    // Full throughput once the pipe has filled.
    repeat (6) tick();
    start = n_pops;
    repeat (8) tick();
    check("throughput_pops", 64'(n_pops - start), 64'(8));

    // Decode stalled: exactly BUF_DEPTH requests, then one pop frees one slot.
    insn_ready = 1'b0;
    do_redirect(30'h300);
    start = req_count;
    repeat (12) tick();
    check("bp_req_count", 64'(req_count - start), 64'(4));
    @(negedge clk);
    check("bp_req_valid", 64'(mem_req_valid), 64'(0));
    check("bp_head_addr", 64'(insn_addr), 64'(30'h300));
    tick();
    insn_ready = 1'b1;
    tick();
    insn_ready = 1'b0;
    start = req_count;
    repeat (8) tick();
    check("bp_one_more_req", 64'(req_count - start), 64'(1));
    insn_ready = 1'b1;
    repeat (6) tick();

    // Two requests outstanding when redirecting: both old responses must vanish.
    rsp_hold = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("hold_req_valid", 64'(mem_req_valid), 64'(0));
    do_redirect(30'h40);
    rsp_hold = 1'b0;
    @(negedge clk);
    check("redirect_flush", 64'(insn_valid), 64'(0));
    wait_insn_addr("redirect_head", 30'h40);
    repeat (4) tick();

    // Fault at 0x102 halts fetching until redirected.
    err_en = 1'b1;
    do_redirect(30'h100);
    for (int i = 0; i < 24 && !err_seen; i++) @(negedge clk);
    check("fault_seen", 64'(err_seen), 64'(1));
    check("fault_addr", 64'(fault_addr), 64'(30'h102));
    tick();
    start = req_count;
    repeat (10) tick();
    @(negedge clk);
    check("halt_no_req", 64'(req_count - start), 64'(0));
    check("halt_req_valid", 64'(mem_req_valid), 64'(0));
    check("halt_drained", 64'(insn_valid), 64'(0));
    err_en = 1'b0;
    do_redirect(30'h200);
    wait_insn_addr("resume_head", 30'h200);
    repeat (4) tick();

    // PC wrap-around at the top of the word address space.
    do_redirect(30'h3fff_ffff);
    @(negedge clk);
    check("wrap_first", 64'(mem_req_addr), 64'(30'h3fff_ffff));
    tick();
    @(negedge clk);
    check("wrap_next", 64'(mem_req_addr), 64'(0));
    check("wrap_known", 64'($isunknown(mem_req_addr)), 64'(0));
    repeat (4) tick();

    // Memory stalls for 5 cycles: the pending request must not move.
    mem_req_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    a0 = mem_req_addr;
    check("stall_valid0", 64'(mem_req_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("stall_valid", 64'(mem_req_valid), 64'(1));
      check("stall_addr", 64'(mem_req_addr), 64'(a0));
    end
    tick();
    mem_req_ready = 1'b1;

    // Asynchronous reset in the middle of a burst, away from any clock edge.
    repeat (5) tick();
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mig_u_fetch.md
Name: mig_u_fetch

Overview:
Instruction fetch front end for the Mig-U core, generalised over address width, buffer depth and outstanding-request count. Holds the fetch PC, issues in-order 32-bit word fetches over a valid/ready memory request channel and buffers in-order responses in a BUF_DEPTH-entry instruction queue. Drains that queue to decode over a valid/ready handshake. Supports redirect (flush and refetch) and fault halting.

Parameters:
ADDR_WIDTH, 32, byte-address width; all addresses are word addresses [ADDR_WIDTH-1:2]
BUF_DEPTH, 4, instruction queue entries; power of two, >= 2
MAX_OUTSTANDING, 2, max accepted-but-unanswered requests; 1..BUF_DEPTH

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
rst_addr  in  ADDR_WIDTH-2  word address of the first fetch after reset
redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_addr
redirect_addr  in  ADDR_WIDTH-2  new fetch word address
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_WIDTH-2  fetch word address
mem_rsp_valid  in  1  response valid, in request order, always accepted
mem_rsp_data  in  32  instruction word
mem_rsp_err  in  1  access fault for this response
insn_valid  out  1  queue head valid
insn_ready  in  1  decode accepts head
insn_data  out  32  head instruction
insn_addr  out  ADDR_WIDTH-2  head word address
insn_err  out  1  head carries fault

Behaviour:
- Reset (async assert): pc=rst_addr, state=RUN, queue empty, outstanding=0, drop=0.
- Reset output values: mem_req_valid=0, mem_req_addr=rst_addr, insn_valid=0, insn_data=0, insn_addr=0, insn_err=0.
- First request: mem_req_valid=1 in the first clk edge-cycle after rst deasserts.
- Issue condition (mem_req_valid): state==RUN && outstanding<MAX_OUTSTANDING && occupancy+outstanding<BUF_DEPTH && !redirect_valid. mem_req_addr=pc.
- Request handshake (valid&&ready): pc<=pc+1, with wrap-around modulo 2^(ADDR_WIDTH-2); outstanding+1.
- Request stability: once mem_req_valid is asserted, valid and addr hold until ready, except on redirect, which may withdraw the request.
- Response: outstanding-1.
  - If drop>0: drop-1 and the response is discarded.
  - Otherwise {data, err, addr} is written to the queue tail. The entry address comes from a response-address counter that increments per accepted response and is reloaded on redirect.
  - The slot reservation in the issue condition guarantees the queue never overflows; a response with outstanding==0 is a protocol error (simulation assertion).
- Queue output: registered queue. An insn appears on the output no earlier than the cycle after its response. insn_valid=!empty; pop on insn_valid&&insn_ready. Simultaneous push and pop on a full or empty queue is legal.
- Fault: when a response with err=1 is enqueued, state goes RUN->HALT. No further requests issue; already outstanding responses are dropped (drop<=outstanding remaining). Entries ahead of and including the faulting one still drain.
- Redirect (in any state), effective the same cycle:
  - Queue is flushed; an insn handshake in that cycle still completes.
  - pc<=redirect_addr; state<=RUN.
  - drop<=outstanding after this cycle's request and response accounting. A request accepted in the redirect cycle cannot occur (valid is gated); a response arriving in the redirect cycle is discarded.
  - The first new request issues in the next cycle.
- Counters are sized clog2(MAX_OUTSTANDING+1); occupancy is sized clog2(BUF_DEPTH+1).

Test Plan:
- Reset with rst_addr=0x100, mem_req_ready=1, 1-cycle response latency, insn_ready=1 -> requests at 0x100, 0x101, ...; insns delivered in order with matching insn_addr, at full throughput after fill.
- insn_ready=0, BUF_DEPTH=4 -> exactly 4 requests accepted, then mem_req_valid=0. One pop -> exactly one new request.
- Two requests outstanding, redirect to 0x40 -> both old responses dropped; next insn_addr=0x40; queue empty in the cycle after redirect.
- Response for 0x102 with err=1 -> insn_err=1 at insn_addr=0x102; no requests until redirect; redirect to 0x200 resumes fetching.
- pc=2^(ADDR_WIDTH-2)-1 -> next request address 0, no X.
- mem_req_ready stalled 5 cycles -> mem_req_valid and mem_req_addr stable throughout. Async rst asserted mid-burst -> all outputs return to their reset values without waiting for a clock edge.
